mem_stage: RTL and testbench

- Memory stage of the 5-stage core, the consuming end of the execute stage's EX/MEM outputs.
- Takes the registered ALU result, store data and control from execute and performs loads and stores over a ready/req data-memory port with variable latency.
- Stalls upstream stages while an access is outstanding.
- Drives the MEM/WB pipeline register and the M-stage forwarding/hazard signals.

---
 rtl/mem_stage.sv | 146 ++++++++++++++
 tb/tb_mem_stage.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage.sv
// Memory stage: turns EX/MEM results into loads/stores on a req/ready data port,
// stalls upstream while an access is outstanding, and drives the MEM/WB register.
module mem_stage #(
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                  clk_i,
    input  logic                  rst_n_i,
    input  logic [DATA_WIDTH-1:0] result_i,
    input  logic [DATA_WIDTH-1:0] read_data2_i,
    input  logic                  wb_sel_i,
    input  logic                  reg_write_enable_i,
    input  logic                  mem_write_enable_i,
    input  logic [4:0]            write_reg_sel_i,
    output logic                  mem_req_o,
    output logic                  mem_we_o,
    output logic [DATA_WIDTH-1:0] mem_addr_o,
    output logic [DATA_WIDTH-1:0] mem_wdata_o,
    input  logic                  mem_ready_i,
    input  logic [DATA_WIDTH-1:0] mem_rdata_i,
    output logic                  stall_o,
    output logic [DATA_WIDTH-1:0] wb_data_o,
    output logic                  reg_write_enable_o,
    output logic [4:0]            write_reg_sel_o,
    output logic [4:0]            m_dest_reg_o,
    output logic                  m_dest_reg_en_o,
    output logic                  bus_err_o,
    output logic                  fsm_state
);

    // Handshake: mem_req_o rises the edge after an access is seen in IDLE and
    // is held, with address/data/we stable, until an edge where mem_ready_i=1
    // (which completes the access) or until the timeout aborts it.

    localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_WAIT = 1'b1
    } state_t;

    state_t        state;
    state_t        state_next;
    logic [CW-1:0] count;
    logic [4:0]    dest_q;
    logic          load_q;
    logic          load;
    logic          access;
    logic          timeout_hit;

    assign load        = wb_sel_i & reg_write_enable_i;
    assign access      = load | mem_write_enable_i;
    assign timeout_hit = (count == CW'(TIMEOUT_CYCLES - 1)) & ~mem_ready_i;
    assign fsm_state   = state;

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: if (access) state_next = S_WAIT;
            S_WAIT: if (mem_ready_i || timeout_hit) state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // Forwarding sees the latched destination while the access is in flight.
    always_comb begin
        stall_o         = 1'b0;
        m_dest_reg_o    = write_reg_sel_i;
        m_dest_reg_en_o = reg_write_enable_i & ~mem_write_enable_i;
        case (state)
            S_IDLE: stall_o = access;
            S_WAIT: begin
                stall_o         = ~mem_ready_i & ~timeout_hit;
                m_dest_reg_o    = dest_q;
                m_dest_reg_en_o = load_q;
            end
            default: stall_o = 1'b0;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            mem_req_o          <= 1'b0;
            mem_we_o           <= 1'b0;
            mem_addr_o         <= '0;
            mem_wdata_o        <= '0;
            wb_data_o          <= '0;
            reg_write_enable_o <= 1'b0;
            write_reg_sel_o    <= 5'd0;
            bus_err_o          <= 1'b0;
            count              <= '0;
            dest_q             <= 5'd0;
            load_q             <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (access) begin
                        mem_addr_o         <= result_i;
                        mem_wdata_o        <= read_data2_i;
                        mem_we_o           <= mem_write_enable_i;
                        dest_q             <= write_reg_sel_i;
                        // A store wins over a load, so it never writes back.
                        load_q             <= load & ~mem_write_enable_i;
                        mem_req_o          <= 1'b1;
                        count              <= '0;
                        reg_write_enable_o <= 1'b0;
                    end else begin
                        wb_data_o          <= result_i;
                        reg_write_enable_o <= reg_write_enable_i;
                        write_reg_sel_o    <= write_reg_sel_i;
                    end
                end
                S_WAIT: begin
                    if (mem_ready_i) begin
                        mem_req_o <= 1'b0;
                        if (load_q) begin
                            wb_data_o          <= mem_rdata_i;
                            reg_write_enable_o <= 1'b1;
                            write_reg_sel_o    <= dest_q;
                        end else begin
                            reg_write_enable_o <= 1'b0;
                        end
                    end else if (timeout_hit) begin
                        mem_req_o          <= 1'b0;
                        bus_err_o          <= 1'b1;
                        reg_write_enable_o <= 1'b0;
                        wb_data_o          <= '0;
                    end else begin
                        count              <= count + CW'(1);
                        reg_write_enable_o <= 1'b0;
                    end
                end
                default: mem_req_o <= 1'b0;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: pass-through, load/store latency, timeout,
// back-to-back load then ALU op, and reset during an outstanding access.
module tb_mem_stage;

    logic        clk;
    logic        rst_n;
    logic [31:0] result;
    logic [31:0] read_data2;
    logic        wb_sel;
    logic        rwe_in;
    logic        mwe_in;
    logic [4:0]  wsel_in;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ready;
    logic [31:0] mem_rdata;
    logic        stall;
    logic [31:0] wb_data;
    logic        rwe_out;
    logic [4:0]  wsel_out;
    logic [4:0]  m_dest;
    logic        m_dest_en;
    logic        bus_err;
    logic        fsm_state;

    int n_cmp = 0;
    int n_err = 0;

    mem_stage #(.DATA_WIDTH(32), .TIMEOUT_CYCLES(4)) dut (
        .clk_i(clk), .rst_n_i(rst_n),
        .result_i(result), .read_data2_i(read_data2),
        .wb_sel_i(wb_sel), .reg_write_enable_i(rwe_in),
        .mem_write_enable_i(mwe_in), .write_reg_sel_i(wsel_in),
        .mem_req_o(mem_req), .mem_we_o(mem_we),
        .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata),
        .mem_ready_i(mem_ready), .mem_rdata_i(mem_rdata),
        .stall_o(stall), .wb_data_o(wb_data),
        .reg_write_enable_o(rwe_out), .write_reg_sel_o(wsel_out),
        .m_dest_reg_o(m_dest), .m_dest_reg_en_o(m_dest_en),
        .bus_err_o(bus_err), .fsm_state(fsm_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_in(input logic [31:0] res, input logic [31:0] rd2, input logic ws,
                          input logic rwe, input logic mwe, input logic [4:0] sel);
        result     = res;
        read_data2 = rd2;
        wb_sel     = ws;
        rwe_in     = rwe;
        mwe_in     = mwe;
        wsel_in    = sel;
    endtask

    initial begin
        rst_n     = 1'b0;
        mem_ready = 1'b0;
        mem_rdata = 32'h0;
        set_in(32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 5'd0);
        tick();
        tick();
        chk("rst_req", 32'(mem_req), 32'h0);
        chk("rst_rwe", 32'(rwe_out), 32'h0);
        chk("rst_buserr", 32'(bus_err), 32'h0);
        chk("rst_wbdata", wb_data, 32'h0);
        chk("rst_stall", 32'(stall), 32'h0);
        rst_n = 1'b1;

        // ALU pass-through
        set_in(32'h1234, 32'h0, 1'b0, 1'b1, 1'b0, 5'd7);
        settle();
        chk("alu_stall_pre", 32'(stall), 32'h0);
        chk("alu_mdest", 32'(m_dest), 32'd7);
        chk("alu_mdest_en", 32'(m_dest_en), 32'h1);
        tick();
        chk("alu_wbdata", wb_data, 32'h1234);
        chk("alu_rwe", 32'(rwe_out), 32'h1);
        chk("alu_wsel", 32'(wsel_out), 32'd7);

        // Load, ready in the 3rd WAIT cycle
        set_in(32'h100, 32'h0, 1'b1, 1'b1, 1'b0, 5'd5);
        settle();
        chk("ld_stall_req_cycle", 32'(stall), 32'h1);
        tick();
        chk("ld_req_w1", 32'(mem_req), 32'h1);
        chk("ld_addr", mem_addr, 32'h100);
        chk("ld_we", 32'(mem_we), 32'h0);
        chk("ld_bubble", 32'(rwe_out), 32'h0);
        chk("ld_stall_w1", 32'(stall), 32'h1);
        chk("ld_state_w1", 32'(fsm_state), 32'h1);
        tick();
        chk("ld_req_w2", 32'(mem_req), 32'h1);
        chk("ld_stall_w2", 32'(stall), 32'h1);
        chk("ld_addr_w2", mem_addr, 32'h100);
        tick();
        mem_ready = 1'b1;
        mem_rdata = 32'hDEADBEEF;
        settle();
        chk("ld_req_w3", 32'(mem_req), 32'h1);
        chk("ld_stall_w3", 32'(stall), 32'h0);
        tick();
        mem_ready = 1'b0;
        set_in(32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 5'd0);
        settle();
        chk("ld_wbdata", wb_data, 32'hDEADBEEF);
        chk("ld_rwe", 32'(rwe_out), 32'h1);
        chk("ld_wsel", 32'(wsel_out), 32'd5);
        chk("ld_req_done", 32'(mem_req), 32'h0);
        tick();

        // Store with load bits also set; ready in the first WAIT cycle
        set_in(32'h40, 32'hA5A5A5A5, 1'b1, 1'b1, 1'b1, 5'd3);
        settle();
        chk("st_stall_req_cycle", 32'(stall), 32'h1);
        chk("st_mdest_en", 32'(m_dest_en), 32'h0);
        tick();
        chk("st_we", 32'(mem_we), 32'h1);
        chk("st_wdata", mem_wdata, 32'hA5A5A5A5);
        chk("st_addr", mem_addr, 32'h40);
        chk("st_req", 32'(mem_req), 32'h1);
        mem_ready = 1'b1;
        settle();
        chk("st_stall_w1", 32'(stall), 32'h0);
        chk("st_mdest_en_w1", 32'(m_dest_en), 32'h0);
        tick();
        mem_ready = 1'b0;
        set_in(32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 5'd0);
        settle();
        chk("st_rwe", 32'(rwe_out), 32'h0);
        chk("st_req_done", 32'(mem_req), 32'h0);
        chk("st_stall_after", 32'(stall), 32'h0);
        tick();

        // Back-to-back: load (ready in 2nd WAIT cycle) then ALU op
        set_in(32'h200, 32'h0, 1'b1, 1'b1, 1'b0, 5'd10);
        settle();
        chk("b2b_stall_req", 32'(stall), 32'h1);
        tick();
        set_in(32'h55, 32'h0, 1'b0, 1'b1, 1'b0, 5'd12);
        settle();
        chk("b2b_mdest_w1", 32'(m_dest), 32'd10);
        chk("b2b_mdest_en_w1", 32'(m_dest_en), 32'h1);
        chk("b2b_stall_w1", 32'(stall), 32'h1);
        tick();
        mem_ready = 1'b1;
        mem_rdata = 32'h11223344;
        settle();
        chk("b2b_mdest_w2", 32'(m_dest), 32'd10);
        chk("b2b_mdest_en_w2", 32'(m_dest_en), 32'h1);
        chk("b2b_stall_w2", 32'(stall), 32'h0);
        tick();
        mem_ready = 1'b0;
        settle();
        chk("b2b_ld_wbdata", wb_data, 32'h11223344);
        chk("b2b_ld_rwe", 32'(rwe_out), 32'h1);
        chk("b2b_ld_wsel", 32'(wsel_out), 32'd10);
        chk("b2b_alu_stall", 32'(stall), 32'h0);
        chk("b2b_alu_mdest", 32'(m_dest), 32'd12);
        tick();
        chk("b2b_alu_wbdata", wb_data, 32'h55);
        chk("b2b_alu_rwe", 32'(rwe_out), 32'h1);
        chk("b2b_alu_wsel", 32'(wsel_out), 32'd12);

        // Timeout: ready never comes, TIMEOUT_CYCLES=4
        set_in(32'h300, 32'h0, 1'b1, 1'b1, 1'b0, 5'd6);
        settle();
        chk("to_stall_req", 32'(stall), 32'h1);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk($sformatf("to_req_w%0d", i), 32'(mem_req), 32'h1);
            chk($sformatf("to_stall_w%0d", i), 32'(stall), (i < 3) ? 32'h1 : 32'h0);
        end
        tick();
        set_in(32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 5'd0);
        settle();
        chk("to_req_drop", 32'(mem_req), 32'h0);
        chk("to_buserr", 32'(bus_err), 32'h1);
        chk("to_rwe", 32'(rwe_out), 32'h0);
        chk("to_wbdata", wb_data, 32'h0);
        chk("to_stall_after", 32'(stall), 32'h0);
        chk("to_state", 32'(fsm_state), 32'h0);
        tick();
        tick();
        chk("to_buserr_sticky", 32'(bus_err), 32'h1);

        // Reset while an access is outstanding
        set_in(32'h400, 32'h0, 1'b1, 1'b1, 1'b0, 5'd8);
        tick();
        chk("rw_req_before", 32'(mem_req), 32'h1);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        set_in(32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 5'd0);
        settle();
        chk("rw_req", 32'(mem_req), 32'h0);
        chk("rw_rwe", 32'(rwe_out), 32'h0);
        chk("rw_buserr", 32'(bus_err), 32'h0);
        chk("rw_stall", 32'(stall), 32'h0);
        chk("rw_addr", mem_addr, 32'h0);
        chk("rw_state", 32'(fsm_state), 32'h0);

        // mem_ready is ignored in IDLE
        set_in(32'hCAFE, 32'h0, 1'b0, 1'b1, 1'b0, 5'd2);
        mem_ready = 1'b1;
        mem_rdata = 32'hFFFF0000;
        tick();
        mem_ready = 1'b0;
        chk("idle_rdy_wbdata", wb_data, 32'hCAFE);
        chk("idle_rdy_rwe", 32'(rwe_out), 32'h1);
        chk("idle_rdy_wsel", 32'(wsel_out), 32'd2);
        chk("idle_rdy_req", 32'(mem_req), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
